pong_game_ctrl: RTL and testbench
=================================

// Module: pong_game_ctrl
// PURPOSE
//  Frame-rate game sequencer for the pong datapath. Derives a once-per-frame tick from the
//  VGA scan position and runs the match state machine: IDLE, SERVE, PLAY, MISS, OVER.
//  Emits per-frame motion enables, ball re-serve pulses, scores, speed level and a miss flash.
//  Sits between the debounced button logic / datapath collision events and the ball/paddle regs.
// PARAMETERS
//  FRAME_X         639  x value marking frame end (with FRAME_Y)
//  FRAME_Y         479  y value marking frame end
//  SERVE_FRAMES    60   frames spent in SERVE before PLAY (1..255)
//  MISS_FRAMES     30   frames spent in MISS before next serve/OVER (1..255)
//  WIN_SCORE       9    score that ends the match (1..15)
//  HITS_PER_LEVEL  4    paddle hits per speed increment (1..15)
//  MAX_SPEED       4    speed saturation value (1..7)
// PORTS
//  clk          in   1   system clock
//  rst          in   1   asynchronous reset, active-high
//  x            in   10  current scan column
//  y            in   9   current scan row
//  btn_start    in   1   debounced start button (level)
//  paddle_hit   in   1   1-cycle pulse: ball hit a paddle
//  miss_l       in   1   1-cycle pulse: ball passed left edge (right player scores)
//  miss_r       in   1   1-cycle pulse: ball passed right edge (left player scores)
//  frame_tick   out  1   1-cycle pulse, once per frame
//  update_en    out  1   1-cycle pulse = frame_tick while state==PLAY
//  ball_reset   out  1   1-cycle pulse on every entry into SERVE
//  serve_dir    out  1   0 = serve toward left, 1 = toward right
//  speed        out  3   current ball speed level, 1..MAX_SPEED
//  score_l      out  4   left player score
//  score_r      out  4   right player score
//  flash        out  1   high on alternate 4-frame blocks while in MISS, else 0
//  game_over    out  1   high while state==OVER
//  state        out  3   IDLE=0 SERVE=1 PLAY=2 MISS=3 OVER=4
// BEHAVIOUR
//  Reset (async, any time): state=IDLE, all pulses 0, scores 0, speed=1, serve_dir=0, flash=0,
//   game_over=0, frame/hit counters 0, start-edge and frame-match history regs cleared.
//  frame_tick: registered; high the cycle after the first clk where (x==FRAME_X && y==FRAME_Y)
//   and previous clk did not match. Holding x/y for many clks yields exactly one tick.
//  btn_start: internal rising-edge detect; only the edge acts. Level ignored otherwise.
//  IDLE: scores held 0, speed=1. start edge -> SERVE (ball_reset next cycle), cnt=SERVE_FRAMES.
//  SERVE: cnt-- on each frame_tick; tick with cnt==1 -> PLAY. paddle_hit/miss_* ignored.
//  PLAY: update_en mirrors frame_tick. paddle_hit: hit_cnt++; at HITS_PER_LEVEL -> hit_cnt=0,
//   speed++ saturating at MAX_SPEED. miss_l: score_r++, serve_dir=0; miss_r: score_l++, serve_dir=1;
//   both same cycle: both scores ++, serve_dir toggles. Any miss -> MISS, cnt=MISS_FRAMES.
//   Miss takes priority over paddle_hit in same cycle (hit discarded).
//  MISS: cnt-- per frame_tick; flash = ~cnt[2]. Tick with cnt==1: if score_l or score_r ==
//   WIN_SCORE -> OVER, else -> SERVE (cnt=SERVE_FRAMES, speed=1, hit_cnt=0, ball_reset).
//  Scores saturate at WIN_SCORE; no wrap. Events outside PLAY never change scores/speed.
//  OVER: game_over=1, scores frozen. start edge -> SERVE with scores=0, speed=1, serve_dir=0.
//  All outputs registered; state/outputs change only on clk except via rst.
// TESTING
//  x/y held at 639/479 for 5 clks -> exactly one frame_tick, one cycle after first match.
//  rst, start edge -> ball_reset 1 cycle, state=1; 60 ticks later state=2; update_en per tick.
//  PLAY, 8 paddle_hits -> speed 1->2->3; 12 more -> speed stays 4 (MAX_SPEED).
//  PLAY, miss_l+miss_r same cycle -> score_l=1, score_r=1, serve_dir toggled, state=3.
//  Drive miss_r 9 times through full serve cycles -> score_l=9, state=4, game_over=1; start -> state=1, scores 0.
//  Assert rst mid-MISS with flash high -> all outputs reset values immediately, state=0.

Source files
------------

// File: rtl/pong_game_ctrl.sv
// rtl/pong_game_ctrl.sv - frame-rate match sequencer for the pong datapath
module pong_game_ctrl #(
  parameter int FRAME_X        = 639,
  parameter int FRAME_Y        = 479,
  parameter int SERVE_FRAMES   = 60,
  parameter int MISS_FRAMES    = 30,
  parameter int WIN_SCORE      = 9,
  parameter int HITS_PER_LEVEL = 4,
  parameter int MAX_SPEED      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] x,
  input  logic [8:0] y,
  input  logic       btn_start,
  input  logic       paddle_hit,
  input  logic       miss_l,
  input  logic       miss_r,
  output logic       frame_tick,
  output logic       update_en,
  output logic       ball_reset,
  output logic       serve_dir,
  output logic [2:0] speed,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic       flash,
  output logic       game_over,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    MISS  = 3'd3,
    OVER  = 3'd4
  } state_t;

  localparam logic [9:0] X_END     = 10'(FRAME_X);
  localparam logic [8:0] Y_END     = 9'(FRAME_Y);
  localparam logic [7:0] SERVE_CNT = 8'(SERVE_FRAMES);
  localparam logic [7:0] MISS_CNT  = 8'(MISS_FRAMES);
  localparam logic [3:0] WIN       = 4'(WIN_SCORE);
  localparam logic [3:0] HIT_LAST  = 4'(HITS_PER_LEVEL - 1);
  localparam logic [2:0] SPD_MAX   = 3'(MAX_SPEED);

  state_t     state_q, state_n;
  logic [7:0] cnt_q, cnt_n;
  logic [3:0] hit_cnt_q, hit_cnt_n;
  logic       match_q, btn_q;
  logic       match, start_edge, enter_serve;
  logic       serve_dir_n;
  logic [2:0] speed_n;
  logic [3:0] score_l_n, score_r_n;

  assign state = state_q;

  // Next-state and next-value logic for the match sequencer
  always_comb begin
    match       = (x == X_END) && (y == Y_END);
    start_edge  = btn_start && !btn_q;
    state_n     = state_q;
    cnt_n       = cnt_q;
    hit_cnt_n   = hit_cnt_q;
    serve_dir_n = serve_dir;
    speed_n     = speed;
    score_l_n   = score_l;
    score_r_n   = score_r;
    enter_serve = 1'b0;
    case (state_q)
      IDLE: begin
        score_l_n = 4'd0;
        score_r_n = 4'd0;
        speed_n   = 3'd1;
        if (start_edge) begin
          state_n     = SERVE;
          cnt_n       = SERVE_CNT;
          hit_cnt_n   = 4'd0;
          enter_serve = 1'b1;
        end
      end
      SERVE: begin
        if (frame_tick) begin
          if (cnt_q == 8'd1) state_n = PLAY;
          else               cnt_n   = cnt_q - 8'd1;
        end
      end
      PLAY: begin
        if (miss_l || miss_r) begin
          if (miss_l && (score_r < WIN)) score_r_n = score_r + 4'd1;
          if (miss_r && (score_l < WIN)) score_l_n = score_l + 4'd1;
          serve_dir_n = (miss_l && miss_r) ? !serve_dir : miss_r;
          state_n     = MISS;
          cnt_n       = MISS_CNT;
        end else if (paddle_hit) begin
          if (hit_cnt_q == HIT_LAST) begin
            hit_cnt_n = 4'd0;
            if (speed < SPD_MAX) speed_n = speed + 3'd1;
          end else begin
            hit_cnt_n = hit_cnt_q + 4'd1;
          end
        end
      end
      MISS: begin
        if (frame_tick) begin
          if (cnt_q == 8'd1) begin
            if ((score_l == WIN) || (score_r == WIN)) begin
              state_n = OVER;
            end else begin
              state_n     = SERVE;
              cnt_n       = SERVE_CNT;
              speed_n     = 3'd1;
              hit_cnt_n   = 4'd0;
              enter_serve = 1'b1;
            end
          end else begin
            cnt_n = cnt_q - 8'd1;
          end
        end
      end
      OVER: begin
        if (start_edge) begin
          state_n     = SERVE;
          cnt_n       = SERVE_CNT;
          score_l_n   = 4'd0;
          score_r_n   = 4'd0;
          speed_n     = 3'd1;
          serve_dir_n = 1'b0;
          hit_cnt_n   = 4'd0;
          enter_serve = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State register; every output is registered from the next-state values
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      hit_cnt_q  <= 4'd0;
      match_q    <= 1'b0;
      btn_q      <= 1'b0;
      frame_tick <= 1'b0;
      update_en  <= 1'b0;
      ball_reset <= 1'b0;
      serve_dir  <= 1'b0;
      speed      <= 3'd1;
      score_l    <= 4'd0;
      score_r    <= 4'd0;
      flash      <= 1'b0;
      game_over  <= 1'b0;
    end else begin
      state_q    <= state_n;
      cnt_q      <= cnt_n;
      hit_cnt_q  <= hit_cnt_n;
      match_q    <= match;
      btn_q      <= btn_start;
      frame_tick <= match && !match_q;
      update_en  <= match && !match_q && (state_n == PLAY);
      ball_reset <= enter_serve;
      serve_dir  <= serve_dir_n;
      speed      <= speed_n;
      score_l    <= score_l_n;
      score_r    <= score_r_n;
      flash      <= (state_n == MISS) && !cnt_n[2];
      game_over  <= (state_n == OVER);
    end
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb/tb_pong_game_ctrl.sv - scoreboard bench for pong_game_ctrl
module tb_pong_game_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] x;
  logic [8:0] y;
  logic       btn_start, paddle_hit, miss_l, miss_r;
  logic       frame_tick, update_en, ball_reset, serve_dir, flash, game_over;
  logic [2:0] speed, state;
  logic [3:0] score_l, score_r;

  always #5 clk = ~clk;

  pong_game_ctrl dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .btn_start(btn_start),
    .paddle_hit(paddle_hit), .miss_l(miss_l), .miss_r(miss_r),
    .frame_tick(frame_tick), .update_en(update_en), .ball_reset(ball_reset),
    .serve_dir(serve_dir), .speed(speed), .score_l(score_l), .score_r(score_r),
    .flash(flash), .game_over(game_over), .state(state)
  );

  // {frame_tick, update_en, ball_reset, serve_dir, speed, score_l, score_r, flash, game_over, state}
  typedef logic [19:0] ovec_t;
  localparam ovec_t RESET_VEC = {4'b0000, 3'd1, 4'd0, 4'd0, 2'b00, 3'd0};

  ovec_t dut_vec;
  assign dut_vec = {frame_tick, update_en, ball_reset, serve_dir, speed,
                    score_l, score_r, flash, game_over, state};

  ovec_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  logic rst_lvl, btn_lvl;

  // Reference model: match phases 0..4 tracked with plain integers
  int m_ph, m_cnt, m_hits, m_spd, m_sl, m_sr, m_dir;
  int m_fl, m_go, m_ft, m_ue, m_br, m_pm, m_pb;

  task automatic check(input string nm, input ovec_t act, input ovec_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  function automatic ovec_t model_vec();
    return {1'(m_ft), 1'(m_ue), 1'(m_br), 1'(m_dir), 3'(m_spd), 4'(m_sl),
            4'(m_sr), 1'(m_fl), 1'(m_go), 3'(m_ph)};
  endfunction

  task automatic model_reset();
    m_ph = 0; m_cnt = 0; m_hits = 0; m_spd = 1; m_sl = 0; m_sr = 0; m_dir = 0;
    m_fl = 0; m_go = 0; m_ft = 0; m_ue = 0; m_br = 0; m_pm = 0; m_pb = 0;
  endtask

  task automatic begin_serve();
    m_cnt = 60; m_spd = 1; m_hits = 0; m_br = 1;
  endtask

  // One clock of game rules applied to the inputs currently driven
  task automatic model_step();
    int match, start, nph;
    if (rst) begin
      model_reset();
    end else begin
      match = (x == 10'd639 && y == 9'd479);
      start = (btn_start && m_pb == 0);
      nph   = m_ph;
      m_br  = 0;
      case (m_ph)
        0: if (start) begin nph = 1; begin_serve(); end
        1: if (m_ft != 0) begin
             if (m_cnt == 1) nph = 2; else m_cnt = m_cnt - 1;
           end
        2: if (miss_l || miss_r) begin
             if (miss_l && miss_r) m_dir = 1 - m_dir; else m_dir = miss_r;
             if (miss_l) m_sr = (m_sr >= 9) ? 9 : m_sr + 1;
             if (miss_r) m_sl = (m_sl >= 9) ? 9 : m_sl + 1;
             nph = 3; m_cnt = 30;
           end else if (paddle_hit) begin
             m_hits = m_hits + 1;
             if (m_hits == 4) begin
               m_hits = 0;
               if (m_spd < 4) m_spd = m_spd + 1;
             end
           end
        3: if (m_ft != 0) begin
             if (m_cnt == 1) begin
               if (m_sl == 9 || m_sr == 9) nph = 4;
               else begin nph = 1; begin_serve(); end
             end else m_cnt = m_cnt - 1;
           end
        default: if (start) begin
             m_sl = 0; m_sr = 0; m_dir = 0; nph = 1; begin_serve();
           end
      endcase
      m_ft = (match != 0 && m_pm == 0);
      m_pm = match;
      m_pb = btn_start;
      m_ph = nph;
      m_ue = (m_ft != 0 && m_ph == 2);
      m_fl = (m_ph == 3 && ((m_cnt / 4) % 2) == 0);
      m_go = (m_ph == 4);
    end
  endtask

  task automatic cyc(input logic [9:0] xi, input logic [8:0] yi,
                     input logic h, input logic ml, input logic mr);
    @(negedge clk);
    rst = rst_lvl; btn_start = btn_lvl;
    x = xi; y = yi; paddle_hit = h; miss_l = ml; miss_r = mr;
    model_step();
    exp_q.push_back(model_vec());
  endtask

  task automatic idle_cyc(input logic h, input logic ml, input logic mr);
    cyc(10'($urandom_range(0, 638)), 9'($urandom_range(0, 511)), h, ml, mr);
  endtask

  // Frame = one matching scan position then two non-matching cycles
  task automatic frames(input int n, input int p_ev);
    for (int i = 0; i < n; i++) begin
      cyc(10'd639, 9'd479, 1'b0, 1'b0, 1'b0);
      repeat (2) idle_cyc($urandom_range(0, 99) < p_ev, $urandom_range(0, 99) < p_ev,
                          $urandom_range(0, 99) < p_ev);
    end
  endtask

  task automatic run_to(input int ph);
    for (int i = 0; i < 400 && m_ph != ph; i++) frames(1, 0);
    if (m_ph != ph) begin
      n_checks++; n_fail++;
      $display("FAIL run_to: phase %0d not reached", ph);
    end
  endtask

  // Monitor: every cycle the DUT presents its registered outputs
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) check("outputs", dut_vec, exp_q.pop_front());
    end
  end

  initial begin
    rst = 1'b1; btn_start = 1'b0; x = '0; y = '0;
    paddle_hit = 1'b0; miss_l = 1'b0; miss_r = 1'b0;
    rst_lvl = 1'b1; btn_lvl = 1'b0;
    model_reset();
    repeat (3) idle_cyc(1'b1, 1'b1, 1'b1);
    rst_lvl = 1'b0;
    repeat (2) idle_cyc(1'b0, 1'b0, 1'b0);
    repeat (5) cyc(10'd639, 9'd479, 1'b0, 1'b0, 1'b0);
    idle_cyc(1'b0, 1'b0, 1'b0);
    idle_cyc(1'b1, 1'b1, 1'b1);
    btn_lvl = 1'b1;
    repeat (2) idle_cyc(1'b0, 1'b0, 1'b0);
    btn_lvl = 1'b0;
    frames(59, 30);
    frames(1, 0);
    for (int i = 0; i < 20; i++) begin
      idle_cyc(1'b1, 1'b0, 1'b0);
      if (i % 3 == 0) frames(1, 0);
    end
    idle_cyc(1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 8; k++) begin
      run_to(2);
      idle_cyc(1'b1, 1'b0, 1'b1);
    end
    run_to(4);
    repeat (3) idle_cyc(1'b1, 1'b1, 1'b1);
    btn_lvl = 1'b1;
    repeat (3) idle_cyc(1'b0, 1'b0, 1'b0);
    btn_lvl = 1'b0;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 19) == 0) btn_lvl = ~btn_lvl;
      cyc(($urandom_range(0, 3) == 0) ? 10'd639 : 10'($urandom_range(0, 638)), 9'd479,
          $urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0, $urandom_range(0, 29) == 0);
    end
    btn_lvl = 1'b0;
    rst_lvl = 1'b1;
    idle_cyc(1'b0, 1'b0, 1'b0);
    rst_lvl = 1'b0;
    idle_cyc(1'b0, 1'b0, 1'b0);
    btn_lvl = 1'b1;
    idle_cyc(1'b0, 1'b0, 1'b0);
    run_to(2);
    idle_cyc(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 20 && m_fl == 0; i++) frames(1, 0);
    @(negedge clk);
    rst = 1'b1; rst_lvl = 1'b1;
    #1;
    check("async_reset", dut_vec, RESET_VEC);
    model_reset();
    exp_q.push_back(model_vec());
    idle_cyc(1'b0, 1'b0, 1'b0);
    rst_lvl = 1'b0; btn_lvl = 1'b0;
    repeat (3) idle_cyc(1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
